// File: rtl/rs_pkg.sv
// Shared types and constants for the integer-ALU reservation station:
// operand/tag widths, ALU opcodes and the stored entry layout.
package rs_pkg;

    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [OP_W-1:0] ALU_AND = 4'd2;
    localparam logic [OP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [OP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [OP_W-1:0] ALU_SLL = 4'd5;
    localparam logic [OP_W-1:0] ALU_SRL = 4'd6;
    localparam logic [OP_W-1:0] ALU_SLT = 4'd7;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  tag;
        logic              rdy1;
        logic [DATA_W-1:0] val1;
        logic [TAG_W-1:0]  tag1;
        logic              rdy2;
        logic [DATA_W-1:0] val2;
        logic [TAG_W-1:0]  tag2;
    } rs_entry_t;

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch, CDB and issue signals of the reservation station; the station
// itself uses the slave modport, its environment the master modport.
interface reservation_station_if;
    import rs_pkg::*;

    logic              flush;
    logic              dispatch_valid;
    logic [OP_W-1:0]   dispatch_op;
    logic [TAG_W-1:0]  dispatch_tag;
    logic              src1_ready;
    logic [DATA_W-1:0] src1_val;
    logic [TAG_W-1:0]  src1_tag;
    logic              src2_ready;
    logic [DATA_W-1:0] src2_val;
    logic [TAG_W-1:0]  src2_tag;
    logic              rs_full;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_val;
    logic              issue_valid;
    logic [OP_W-1:0]   issue_op;
    logic [TAG_W-1:0]  issue_tag;
    logic [DATA_W-1:0] issue_src1;
    logic [DATA_W-1:0] issue_src2;
    logic              issue_ready;

    modport master (
        output flush, dispatch_valid, dispatch_op, dispatch_tag,
               src1_ready, src1_val, src1_tag, src2_ready, src2_val, src2_tag,
               cdb_valid, cdb_tag, cdb_val, issue_ready,
        input  rs_full, issue_valid, issue_op, issue_tag, issue_src1, issue_src2
    );

    modport slave (
        input  flush, dispatch_valid, dispatch_op, dispatch_tag,
               src1_ready, src1_val, src1_tag, src2_ready, src2_val, src2_tag,
               cdb_valid, cdb_tag, cdb_val, issue_ready,
        output rs_full, issue_valid, issue_op, issue_tag, issue_src1, issue_src2
    );

endinterface

// File: rtl/rs_priority_enc.sv
// Lowest-set-bit encoder: reports whether any request bit is set and the
// index of the lowest one.
module rs_priority_enc #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic [DEPTH-1:0] req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan high-to-low so the lowest set bit is written last and wins
  always_comb begin
    found = |req;
    idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      idx = req[i] ? IDX_W'(i) : idx;
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: holds dispatched ALU ops until both operands are
// captured (at dispatch, by same-cycle CDB bypass or by later wakeup).
module reservation_station
  import rs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  reservation_station_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rs_entry_t        entries_r [DEPTH];
  rs_entry_t        new_entry_s;
  logic [DEPTH-1:0] valid_vec_s;
  logic [DEPTH-1:0] ready_vec_s;
  logic             free_found_s;
  logic             ready_found_s;
  logic [IDX_W-1:0] free_idx_s;
  logic [IDX_W-1:0] ready_idx_s;
  logic             dispatch_fire_s;
  logic             issue_fire_s;

  // Occupancy and issue eligibility of every entry
  always_comb begin
    valid_vec_s = '0;
    ready_vec_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec_s[i] = entries_r[i].valid;
      ready_vec_s[i] = entries_r[i].valid & entries_r[i].rdy1 & entries_r[i].rdy2;
    end
  end

  rs_priority_enc #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_free_enc (
    .req   (~valid_vec_s),
    .found (free_found_s),
    .idx   (free_idx_s)
  );

  rs_priority_enc #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ready_enc (
    .req   (ready_vec_s),
    .found (ready_found_s),
    .idx   (ready_idx_s)
  );

  assign bus.rs_full     = &valid_vec_s;
  assign dispatch_fire_s = bus.dispatch_valid && free_found_s && !bus.flush;
  assign issue_fire_s    = ready_found_s && bus.issue_ready;

  // Issue port mirrors the selected entry and reads zero when nothing is ready
  always_comb begin
    if (ready_found_s) begin
      bus.issue_valid = 1'b1;
      bus.issue_op    = entries_r[ready_idx_s].op;
      bus.issue_tag   = entries_r[ready_idx_s].tag;
      bus.issue_src1  = entries_r[ready_idx_s].val1;
      bus.issue_src2  = entries_r[ready_idx_s].val2;
    end else begin
      bus.issue_valid = 1'b0;
      bus.issue_op    = '0;
      bus.issue_tag   = '0;
      bus.issue_src1  = '0;
      bus.issue_src2  = '0;
    end
  end

  // Incoming entry, with each operand optionally bypassed from the CDB
  always_comb begin
    new_entry_s       = '0;
    new_entry_s.valid = 1'b1;
    new_entry_s.op    = bus.dispatch_op;
    new_entry_s.tag   = bus.dispatch_tag;
    new_entry_s.tag1  = bus.src1_tag;
    new_entry_s.tag2  = bus.src2_tag;
    if (bus.src1_ready) begin
      new_entry_s.rdy1 = 1'b1;
      new_entry_s.val1 = bus.src1_val;
    end else if (bus.cdb_valid && (bus.cdb_tag == bus.src1_tag)) begin
      new_entry_s.rdy1 = 1'b1;
      new_entry_s.val1 = bus.cdb_val;
    end else begin
      new_entry_s.rdy1 = 1'b0;
      new_entry_s.val1 = bus.src1_val;
    end
    if (bus.src2_ready) begin
      new_entry_s.rdy2 = 1'b1;
      new_entry_s.val2 = bus.src2_val;
    end else if (bus.cdb_valid && (bus.cdb_tag == bus.src2_tag)) begin
      new_entry_s.rdy2 = 1'b1;
      new_entry_s.val2 = bus.cdb_val;
    end else begin
      new_entry_s.rdy2 = 1'b0;
      new_entry_s.val2 = bus.src2_val;
    end
  end

  // Entry storage: reset/flush clear all; else dispatch, issue-free or wakeup
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (dispatch_fire_s && (free_idx_s == IDX_W'(i))) begin
          entries_r[i] <= new_entry_s;
        end else if (issue_fire_s && (ready_idx_s == IDX_W'(i))) begin
          entries_r[i].valid <= 1'b0;
        end else if (entries_r[i].valid && bus.cdb_valid) begin
          if (!entries_r[i].rdy1 && (entries_r[i].tag1 == bus.cdb_tag)) begin
            entries_r[i].rdy1 <= 1'b1;
            entries_r[i].val1 <= bus.cdb_val;
          end
          if (!entries_r[i].rdy2 && (entries_r[i].tag2 == bus.cdb_tag)) begin
            entries_r[i].rdy2 <= 1'b1;
            entries_r[i].val2 <= bus.cdb_val;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios plus random traffic,
// checked every cycle against a slot-array model of the station's rules.
module tb_reservation_station;
  import rs_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reservation_station_if rif();

  reservation_station #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rif)
  );

  typedef struct {
    bit                valid;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tag;
    bit                r1;
    logic [DATA_W-1:0] v1;
    logic [TAG_W-1:0]  t1;
    bit                r2;
    logic [DATA_W-1:0] v2;
    logic [TAG_W-1:0]  t2;
  } slot_t;

  slot_t m [DEPTH];
  bit    model_live = 1'b0;
  int    n_compared = 0;
  int    n_mismatched = 0;

  logic [OP_W-1:0] op_tab [8];

  function automatic int pick_ready();
    for (int i = 0; i < DEPTH; i++)
      if (m[i].valid && m[i].r1 && m[i].r2) return i;
    return -1;
  endfunction

  function automatic bit all_full();
    for (int i = 0; i < DEPTH; i++)
      if (!m[i].valid) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m[i].valid = 1'b0;
  endtask

  // Apply one clock edge worth of station rules to the model
  task automatic model_step();
    int sel;
    int fr;
    bit full;
    if (rst) begin
      model_clear();
      model_live = 1'b1;
      return;
    end
    if (!model_live) return;
    if (rif.flush) begin
      model_clear();
      return;
    end
    sel  = pick_ready();
    full = all_full();
    fr   = -1;
    for (int i = 0; i < DEPTH; i++)
      if (!m[i].valid && fr < 0) fr = i;
    if (rif.cdb_valid)
      for (int i = 0; i < DEPTH; i++)
        if (m[i].valid) begin
          if (!m[i].r1 && m[i].t1 == rif.cdb_tag) begin m[i].r1 = 1'b1; m[i].v1 = rif.cdb_val; end
          if (!m[i].r2 && m[i].t2 == rif.cdb_tag) begin m[i].r2 = 1'b1; m[i].v2 = rif.cdb_val; end
        end
    if (sel >= 0 && rif.issue_ready) m[sel].valid = 1'b0;
    if (rif.dispatch_valid && !full) begin
      m[fr].valid = 1'b1;
      m[fr].op    = rif.dispatch_op;
      m[fr].tag   = rif.dispatch_tag;
      m[fr].t1    = rif.src1_tag;
      m[fr].t2    = rif.src2_tag;
      m[fr].r1    = rif.src1_ready || (rif.cdb_valid && rif.cdb_tag == rif.src1_tag);
      m[fr].v1    = rif.src1_ready ? rif.src1_val : rif.cdb_val;
      m[fr].r2    = rif.src2_ready || (rif.cdb_valid && rif.cdb_tag == rif.src2_tag);
      m[fr].v2    = rif.src2_ready ? rif.src2_val : rif.cdb_val;
    end
  endtask

  always @(posedge clk) model_step();

  // Compare process: outputs depend only on stored state, so check mid-cycle
  always @(negedge clk) begin : cmp
    int sel;
    if (model_live) begin
      sel = pick_ready();
      check("rs_full", 64'(rif.rs_full), 64'(all_full()));
      check("issue_valid", 64'(rif.issue_valid), 64'(sel >= 0));
      check("issue_op", 64'(rif.issue_op), (sel >= 0) ? 64'(m[sel].op) : 64'd0);
      check("issue_tag", 64'(rif.issue_tag), (sel >= 0) ? 64'(m[sel].tag) : 64'd0);
      check("issue_src1", 64'(rif.issue_src1), (sel >= 0) ? 64'(m[sel].v1) : 64'd0);
      check("issue_src2", 64'(rif.issue_src2), (sel >= 0) ? 64'(m[sel].v2) : 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rif.flush          = 1'b0;
    rif.dispatch_valid = 1'b0;
    rif.dispatch_op    = '0;
    rif.dispatch_tag   = '0;
    rif.src1_ready     = 1'b0;
    rif.src1_val       = '0;
    rif.src1_tag       = '0;
    rif.src2_ready     = 1'b0;
    rif.src2_val       = '0;
    rif.src2_tag       = '0;
    rif.cdb_valid      = 1'b0;
    rif.cdb_tag        = '0;
    rif.cdb_val        = '0;
    rif.issue_ready    = 1'b1;
  endtask

  task automatic disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] tag,
                      input bit r1, input logic [DATA_W-1:0] v1, input logic [TAG_W-1:0] t1,
                      input bit r2, input logic [DATA_W-1:0] v2, input logic [TAG_W-1:0] t2);
    rif.dispatch_valid = 1'b1;
    rif.dispatch_op    = op;
    rif.dispatch_tag   = tag;
    rif.src1_ready     = r1;
    rif.src1_val       = v1;
    rif.src1_tag       = t1;
    rif.src2_ready     = r2;
    rif.src2_val       = v2;
    rif.src2_tag       = t2;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] val);
    rif.cdb_valid = 1'b1;
    rif.cdb_tag   = tag;
    rif.cdb_val   = val;
  endtask

  initial begin
    op_tab = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT};
    idle();
    rst = 1'b1;

    // Reset holds off a pending dispatch
    disp(ALU_ADD, 5'd1, 1'b1, 32'h1, 5'd0, 1'b1, 32'h2, 5'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_full", 64'(rif.rs_full), 64'd0);
      check("rst_valid", 64'(rif.issue_valid), 64'd0);
      check("rst_tag", 64'(rif.issue_tag), 64'd0);
      check("rst_src1", 64'(rif.issue_src1), 64'd0);
    end
    rst = 1'b0;
    rif.dispatch_valid = 1'b0;
    step();
    check("post_rst_valid", 64'(rif.issue_valid), 64'd0);

    // Ready dispatch issues one cycle later
    disp(4'd2, 5'd3, 1'b1, 32'h10, 5'd0, 1'b1, 32'h20, 5'd0);
    step();
    rif.dispatch_valid = 1'b0;
    check("rdy_valid", 64'(rif.issue_valid), 64'd1);
    check("rdy_tag", 64'(rif.issue_tag), 64'd3);
    check("rdy_op", 64'(rif.issue_op), 64'd2);
    check("rdy_src1", 64'(rif.issue_src1), 64'h10);
    check("rdy_src2", 64'(rif.issue_src2), 64'h20);
    step();
    check("rdy_drained", 64'(rif.issue_valid), 64'd0);

    // Wakeup from the CDB two cycles after dispatch
    disp(ALU_SUB, 5'd4, 1'b0, 32'h0, 5'd1, 1'b1, 32'h7, 5'd0);
    step();
    rif.dispatch_valid = 1'b0;
    check("wait_valid", 64'(rif.issue_valid), 64'd0);
    step();
    cdb(5'd1, 32'hDEAD);
    step();
    rif.cdb_valid = 1'b0;
    check("wake_valid", 64'(rif.issue_valid), 64'd1);
    check("wake_src1", 64'(rif.issue_src1), 64'hDEAD);
    check("wake_src2", 64'(rif.issue_src2), 64'h7);
    check("wake_tag", 64'(rif.issue_tag), 64'd4);
    step();

    // Same-cycle bypass
    disp(ALU_AND, 5'd5, 1'b1, 32'h1, 5'd0, 1'b0, 32'h0, 5'd7);
    cdb(5'd7, 32'h55);
    step();
    rif.dispatch_valid = 1'b0;
    rif.cdb_valid = 1'b0;
    check("byp_valid", 64'(rif.issue_valid), 64'd1);
    check("byp_src2", 64'(rif.issue_src2), 64'h55);
    check("byp_tag", 64'(rif.issue_tag), 64'd5);
    step();
    check("byp_drained", 64'(rif.issue_valid), 64'd0);

    // Fill, drop the fifth dispatch, stall then drain in index order
    rif.issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      disp(ALU_OR, TAG_W'(8 + k), 1'b0, 32'h0, 5'd2, 1'b1, DATA_W'(k), 5'd0);
      step();
    end
    check("full_set", 64'(rif.rs_full), 64'd1);
    disp(ALU_OR, 5'd12, 1'b1, 32'h0, 5'd0, 1'b1, 32'h0, 5'd0);
    step();
    rif.dispatch_valid = 1'b0;
    check("full_drop", 64'(rif.rs_full), 64'd1);
    check("full_novalid", 64'(rif.issue_valid), 64'd0);
    cdb(5'd2, 32'h22);
    step();
    rif.cdb_valid = 1'b0;
    check("stall_tag", 64'(rif.issue_tag), 64'd8);
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_hold", 64'(rif.issue_tag), 64'd8);
      check("stall_valid", 64'(rif.issue_valid), 64'd1);
    end
    rif.issue_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      step();
      check("drain_tag", 64'(rif.issue_tag), 64'(8 + k));
      check("drain_src1", 64'(rif.issue_src1), 64'h22);
    end
    step();
    check("drain_empty", 64'(rif.issue_valid), 64'd0);

    // Flush discards entries and a same-cycle dispatch
    for (int k = 0; k < 3; k++) begin
      disp(ALU_XOR, TAG_W'(13 + k), 1'b0, 32'h0, TAG_W'(20 + k), 1'b1, 32'h3, 5'd0);
      step();
    end
    disp(ALU_XOR, 5'd16, 1'b1, 32'h9, 5'd0, 1'b1, 32'h9, 5'd0);
    rif.flush = 1'b1;
    step();
    rif.flush = 1'b0;
    rif.dispatch_valid = 1'b0;
    check("flush_full", 64'(rif.rs_full), 64'd0);
    check("flush_valid", 64'(rif.issue_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      cdb(TAG_W'(20 + k), 32'hBEEF);
      step();
      check("flush_wake", 64'(rif.issue_valid), 64'd0);
    end
    rif.cdb_valid = 1'b0;

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst                = ($urandom_range(0, 199) == 0);
      rif.flush          = ($urandom_range(0, 49) == 0);
      rif.dispatch_valid = ($urandom_range(0, 9) < 6);
      rif.dispatch_op    = op_tab[$urandom_range(0, 7)];
      rif.dispatch_tag   = TAG_W'($urandom_range(0, 31));
      rif.src1_ready     = ($urandom_range(0, 1) == 1);
      rif.src1_val       = $urandom;
      rif.src1_tag       = TAG_W'($urandom_range(0, 7));
      rif.src2_ready     = ($urandom_range(0, 1) == 1);
      rif.src2_val       = $urandom;
      rif.src2_tag       = TAG_W'($urandom_range(0, 7));
      rif.cdb_valid      = ($urandom_range(0, 1) == 1);
      rif.cdb_tag        = TAG_W'($urandom_range(0, 7));
      rif.cdb_val        = $urandom;
      rif.issue_ready    = ($urandom_range(0, 9) < 7);
      step();
    end
    rst = 1'b0;
    idle();
    for (int k = 0; k < 4; k++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Operand-wait buffer between dispatch and the integer ALU, upstream of the reorder buffer.
- Accepts decoded ops carrying their ROB tag (alloc_tag), holds them until both source operands are available, then issues them to the ALU.
- ALU results return on the CDB, which the reorder buffer also snoops.
- The block watches the same CDB (cdb_valid/cdb_tag/cdb_val) to wake waiting operands.

Parameters:
- DEPTH, 4, number of entries.
- TAG_W, 5, ROB tag width; matches the reorder buffer's alloc_tag.
- DATA_W, 32, operand width.
- OP_W, 4, ALU opcode width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  discard all entries (mispredict/exception).
- dispatch_valid  in  1  new op presented.
- dispatch_op  in  OP_W  ALU opcode.
- dispatch_tag  in  TAG_W  ROB tag of the op's result.
- src1_ready  in  1  src1_val valid at dispatch.
- src1_val  in  DATA_W  operand 1 value.
- src1_tag  in  TAG_W  producer tag when not ready.
- src2_ready, src2_val, src2_tag  in  1/DATA_W/TAG_W  same for operand 2.
- rs_full  out  1  no free entry; dispatch is ignored.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_val  in  DATA_W  broadcast value.
- issue_valid  out  1  an entry is ready to execute.
- issue_op  out  OP_W  opcode of the selected entry.
- issue_tag  out  TAG_W  ROB tag of the selected entry.
- issue_src1, issue_src2  out  DATA_W  operand values.
- issue_ready  in  1  ALU accepts this cycle.

Behaviour:
- Reset/state:
  - Each entry holds valid, op, tag, and per operand a rdy bit, value and tag.
  - rst high at a clock edge clears every valid bit and stops operand capture.
  - Reset values: rs_full=0, issue_valid=0, issue_op/issue_tag/issue_src1/issue_src2 = 0.
  - rst overrides dispatch, CDB and issue in the same cycle.
- Dispatch:
  - Accepted at the edge when dispatch_valid && !rs_full && !flush.
  - Written into the lowest-index free entry.
  - rs_full is combinational from the current valid bits: all DEPTH valid.
  - An entry freed by issue in the same cycle does not allow a dispatch when rs_full=1; that dispatch is dropped.
  - The upstream must hold dispatch_valid and retry.
- Same-cycle bypass:
  - Applies when a dispatched operand is not ready, cdb_valid=1 and cdb_tag equals that operand's srcN_tag.
  - The operand is written ready with cdb_val.
  - Applies to each operand independently.
- Wakeup:
  - Every valid entry with a not-ready operand whose tag equals cdb_tag while cdb_valid=1 captures cdb_val and sets rdy at the edge.
  - Multiple entries may wake on one broadcast.
- Issue select:
  - issue_valid is combinational: any valid entry with both operands ready.
  - Selection is the lowest-index such entry; no age ordering.
  - issue_* show the selected entry's fields and read 0 when issue_valid=0.
  - Minimum latency: dispatch with both operands ready, or bypassed, at edge N gives issue_valid high after edge N.
  - An operand woken at edge N allows issue from edge N on; there is no same-cycle wake-and-issue before the edge.
- Handshake:
  - The entry is freed at the edge where issue_valid && issue_ready.
  - While issue_ready=0, issue_* stay stable unless a lower-index entry becomes ready. Higher priority is allowed; the ALU must tolerate the change.
- Flush:
  - Clears all valid bits at the edge.
  - Same-cycle dispatch and wakeups are discarded.
  - issue_valid reads 0 from the next cycle.
- Tags:
  - A tag of 0 is a legal tag.
  - Tag compare is equality on TAG_W bits only; the block performs no duplicate-tag checking.

Decomposition:
- Shared package rs_pkg holds:
  - constants TAG_W, DATA_W, OP_W;
  - the rs_entry_t struct (valid, op, tag, rdy1, val1, tag1, rdy2, val2, tag2);
  - ALU opcode localparams shared with the ALU.
- One sub-module, rs_priority_enc:
  - a DEPTH-bit lowest-set-bit encoder with a found flag;
  - instantiated twice, once for free-slot select and once for ready-entry select.

Test Plan:
1. Reset: rst=1 for 3 cycles with dispatch_valid=1 -> rs_full=0, issue_valid=0, all issue_* = 0; no entry written.
2. Ready dispatch:
   - Stimulus: op=2, tag=3, src1=0x10 ready, src2=0x20 ready, issue_ready=1.
   - Response: next cycle issue_valid=1, issue_tag=3, issue_op=2, src1=0x10, src2=0x20; following cycle issue_valid=0.
3. Wakeup:
   - Stimulus: dispatch tag=4 with src1 waiting on tag 1, src2=0x7 ready; two cycles later cdb_valid=1, cdb_tag=1, cdb_val=0xDEAD.
   - Response: issue_valid=1 after that edge with issue_src1=0xDEAD and issue_tag=4.
4. Bypass: dispatch tag=5 with src2 waiting on tag 7 in the same cycle as cdb tag=7, val=0x55 -> next cycle issue_valid=1, issue_src2=0x55.
5. Full, priority and stall:
   - Dispatch tags 8–11, all with src1 waiting on tag 2, then a fifth dispatch -> rs_full=1 and the fifth is dropped.
   - Broadcast tag 2 with issue_ready=0 -> issue_tag=8, held stable for 3 cycles.
   - Set issue_ready=1 -> tags 8, 9, 10, 11 issue on successive cycles.
6. Flush:
   - Three waiting entries plus a dispatch in the same cycle as flush=1 -> next cycle rs_full=0, issue_valid=0.
   - A later cdb broadcast of their tags issues nothing.
